sr_drive_ctrl: RTL
==================

SR_DRIVE_CTRL -- requirements
Module: sr_drive_ctrl

Interface
REQ-001 SHALL have parameter PULSE_W, default 4, meaning the number of clk cycles S or R is held high per command (legal range 1..255).
REQ-002 SHALL have parameter GAP_W, default 2, meaning the number of dead-time cycles with S=R=0 after each pulse (legal range 1..255).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on the rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port cmd_valid  input  1  command request.
REQ-006 SHALL have port cmd_op  input  1  command: 1=set, 0=reset; sampled with cmd_valid.
REQ-007 SHALL have port cmd_ready  output  1  high when a command can be accepted.
REQ-008 SHALL have port S  output  1  set drive to the downstream SR latch, registered.
REQ-009 SHALL have port R  output  1  reset drive to the downstream SR latch, registered.
REQ-010 SHALL have port q_fb  input  1  latch Q fed back.
REQ-011 SHALL have port qbar_fb  input  1  latch Qbar fed back.
REQ-012 SHALL have port shadow_q  output  1  expected latch state after the last completed command.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port err  output  1  sticky feedback-mismatch flag.
REQ-015 SHALL have port err_clr  input  1  clears err.

Function
REQ-016 SHALL implement the FSM states IDLE, DRIVE, GAP and CHECK.
REQ-017 cmd_ready SHALL be 1 only in IDLE; a command is accepted on an edge where cmd_valid and cmd_ready are both 1.
REQ-018 On acceptance at edge T, S (cmd_op=1) or R (cmd_op=0) SHALL be high for cycles T+1 through T+PULSE_W; the FSM SHALL enter DRIVE.
REQ-019 The GAP state SHALL follow DRIVE for exactly GAP_W cycles with S=R=0.
REQ-020 The CHECK state SHALL last one cycle at T+PULSE_W+GAP_W+1, sample q_fb and qbar_fb, and load shadow_q with cmd_op.
REQ-021 CHECK SHALL set err if q_fb != cmd_op or q_fb == qbar_fb; the FSM SHALL then return to IDLE, so cmd_ready is 1 again at T+PULSE_W+GAP_W+2.
REQ-022 S and R SHALL never be 1 in the same cycle, under any input sequence.
REQ-023 cmd_valid while busy SHALL be ignored; the command is not queued.
REQ-024 The down-counter SHALL be 8 bits; PULSE_W=1 and GAP_W=1 SHALL each give exactly one cycle in their state.
REQ-025 If err_clr and an error detection occur in the same cycle, err SHALL end up 1 (detection wins).
REQ-026 err_clr alone SHALL clear err at the next edge; err SHALL NOT block command acceptance.

Reset
REQ-027 While reset=1 at an edge, the block SHALL enter IDLE and set S=0, R=0, shadow_q=0, err=0, busy=0 and the counter to 0; cmd_ready SHALL be 1 after reset deasserts.
REQ-028 Reset in DRIVE or GAP SHALL abort the command; S and R SHALL be 0 from the next edge, and shadow_q SHALL be 0.
REQ-029 Reset SHALL take priority over cmd_valid and err_clr.

Configuration
REQ-030 Macro SR_SKIP_REDUNDANT_EN, when defined: a command accepted with cmd_op == shadow_q and err=0 SHALL generate no pulse; the FSM SHALL go directly to CHECK, so cmd_ready returns 1 two cycles after acceptance.
REQ-031 When SR_SKIP_REDUNDANT_EN is undefined, every accepted command SHALL run the full DRIVE/GAP/CHECK sequence.

Verification
REQ-032 Scenario: PULSE_W=4, GAP_W=2, latch model attached, set command at edge 0 -> S high cycles 1-4, S=R=0 cycles 5-6, CHECK at cycle 7, shadow_q=1, err=0, cmd_ready=1 at cycle 8.
REQ-033 Scenario: set, then reset command, then continuous random cmd_valid/cmd_op for 1000 cycles -> S&R never 1 together; commands issued while busy produce no pulse.
REQ-034 Scenario: q_fb held 0 during a set command -> err=1 after CHECK; err_clr pulsed together with a second failing CHECK -> err stays 1; err_clr alone -> err=0.
REQ-035 Scenario: reset asserted at cycle 2 of DRIVE -> S=0 at the next edge, shadow_q=0, cmd_ready=1 after release.
REQ-036 Scenario: SR_SKIP_REDUNDANT_EN defined, shadow_q=1, set command -> no S pulse, cmd_ready=1 two cycles later; same stimulus with the macro undefined -> full 4-cycle S pulse.
REQ-037 Scenario: PULSE_W=1, GAP_W=1 -> S high for exactly 1 cycle, then 1 gap cycle, then CHECK, then cmd_ready=1 at cycle 4.

Source files
------------

// File: rtl/sr_drive_ctrl.sv
// Pulse driver for an external SR latch: timed S/R pulse, dead time, feedback check.
// Optional macro SR_SKIP_REDUNDANT_EN skips the pulse when the latch already holds the requested value.
module sr_drive_ctrl #(
   parameter int unsigned PULSE_W = 4,
   parameter int unsigned GAP_W   = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic cmd_valid,
   input  logic cmd_op,
   output logic cmd_ready,
   output logic S,
   output logic R,
   input  logic q_fb,
   input  logic qbar_fb,
   output logic shadow_q,
   output logic busy,
   output logic err,
   input  logic err_clr
);

   typedef enum logic [1:0] {IDLE, DRIVE, GAP, CHECK} state_t;

   localparam logic [7:0] PULSE_LD = 8'(PULSE_W - 1);
   localparam logic [7:0] GAP_LD   = 8'(GAP_W - 1);

   state_t     state, state_nxt;
   logic [7:0] cnt, cnt_nxt;
   logic       op, op_nxt;
   logic       s_nxt, r_nxt, shadow_nxt, err_nxt;
   logic       skip;

`ifdef SR_SKIP_REDUNDANT_EN
   assign skip = (cmd_op == shadow_q) && !err;
`else
   assign skip = 1'b0;
`endif

   assign cmd_ready = (state == IDLE);
   assign busy      = (state != IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= 8'd0;
         op       <= 1'b0;
         S        <= 1'b0;
         R        <= 1'b0;
         shadow_q <= 1'b0;
         err      <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         op       <= op_nxt;
         S        <= s_nxt;
         R        <= r_nxt;
         shadow_q <= shadow_nxt;
         err      <= err_nxt;
      end
   end

   // S/R are derived from a single op bit, so they can never both be high.
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      op_nxt     = op;
      s_nxt      = 1'b0;
      r_nxt      = 1'b0;
      shadow_nxt = shadow_q;
      err_nxt    = err_clr ? 1'b0 : err;
      case (state)
         IDLE: begin
            if (cmd_valid) begin
               op_nxt = cmd_op;
               if (skip) begin
                  state_nxt = CHECK;
                  cnt_nxt   = 8'd0;
               end else begin
                  state_nxt = DRIVE;
                  cnt_nxt   = PULSE_LD;
                  s_nxt     = cmd_op;
                  r_nxt     = !cmd_op;
               end
            end
         end
         DRIVE: begin
            if (cnt == 8'd0) begin
               state_nxt = GAP;
               cnt_nxt   = GAP_LD;
            end else begin
               cnt_nxt = cnt - 8'd1;
               s_nxt   = op;
               r_nxt   = !op;
            end
         end
         GAP: begin
            if (cnt == 8'd0) state_nxt = CHECK;
            else             cnt_nxt   = cnt - 8'd1;
         end
         CHECK: begin
            shadow_nxt = op;
            // Detection overrides a simultaneous clear.
            if ((q_fb != op) || (q_fb == qbar_fb)) err_nxt = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule
